multicycle_ctrl: RTL and testbench

Multicycle control sequencer for the RV32I CPU datapath. It replaces the single-cycle combinational control path. The block steps each instruction through fetch, decode, execute, memory and writeback states, and drives the enables and mux selects for the PC, instruction register, register file, ALU and a single shared instruction/data memory port. It tolerates variable memory latency through a ready handshake, halts on unsupported opcodes, and counts retired instructions.

---
 rtl/multicycle_ctrl_if.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 175 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle sequencer and the
// RV32I datapath plus shared memory port.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             mem_addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             reg_we;
  logic             mem_to_reg;
  logic             retire;
  logic             halted;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       state_dbg;

  modport master (
    input  opcode, funct3, alu_zero, mem_ready,
    output mem_req, mem_we, mem_addr_sel,
    output ir_we, pc_we, pc_src,
    output alu_src_a, alu_src_b, alu_op,
    output reg_we, mem_to_reg,
    output retire, halted, instr_count, state_dbg
  );

  modport slave (
    output opcode, funct3, alu_zero, mem_ready,
    input  mem_req, mem_we, mem_addr_sel,
    input  ir_we, pc_we, pc_src,
    input  alu_src_a, alu_src_b, alu_op,
    input  reg_we, mem_to_reg,
    input  retire, halted, instr_count, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH
// with memory ready handshake, HALT on bad opcodes, retire counter.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_BR, C_BAD
  } cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_e             cls;
  logic             taken;

  logic       req, we, asel;
  logic       irwe, pcwe, pcsrc;
  logic [1:0] sa, sb, op;
  logic       rwe, m2r, ret;

  always_comb begin
    cls = C_BAD;
    unique case (1'b1)
      (bus.opcode == OP_R):  cls = C_R;
      (bus.opcode == OP_I):  cls = C_I;
      (bus.opcode == OP_LD): cls = C_LD;
      (bus.opcode == OP_ST): cls = C_ST;
      (bus.opcode == OP_BR): cls = C_BR;
      default:               cls = C_BAD;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (bus.funct3)
      3'b000:  taken = bus.alu_zero;
      3'b001:  taken = ~bus.alu_zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    we      = 1'b0;
    asel    = 1'b0;
    irwe    = 1'b0;
    pcwe    = 1'b0;
    pcsrc   = 1'b0;
    sa      = 2'b00;
    sb      = 2'b00;
    op      = 2'b00;
    rwe     = 1'b0;
    m2r     = 1'b0;
    ret     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        req = 1'b1;
        sb  = 2'b01;
        if (bus.mem_ready) begin
          irwe    = 1'b1;
          pcwe    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        sa = 2'b01;
        sb = 2'b10;
        unique case (cls)
          C_R, C_I, C_LD, C_ST: state_d = S_EXEC;
          C_BR:                 state_d = S_BRANCH;
          default:              state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        sa = 2'b10;
        sb = (cls == C_R) ? 2'b00 : 2'b10;
        op = (cls == C_R || cls == C_I) ? 2'b10 : 2'b00;
        state_d = (cls == C_LD || cls == C_ST) ? S_MEM : S_WB;
      end
      S_MEM: begin
        req  = 1'b1;
        asel = 1'b1;
        we   = (cls == C_ST);
        if (bus.mem_ready) begin
          ret     = (cls == C_ST);
          state_d = (cls == C_ST) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        rwe     = 1'b1;
        m2r     = (cls == C_LD);
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        sa      = 2'b10;
        op      = 2'b01;
        pcwe    = taken;
        pcsrc   = taken;
        ret     = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    // Reset in flight kills any pending access or write immediately
    if (!reset_n) begin
      req   = 1'b0;
      we    = 1'b0;
      asel  = 1'b0;
      irwe  = 1'b0;
      pcwe  = 1'b0;
      pcsrc = 1'b0;
      sa    = 2'b00;
      sb    = 2'b00;
      op    = 2'b00;
      rwe   = 1'b0;
      m2r   = 1'b0;
      ret   = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ret) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_req      = req;
  assign bus.mem_we       = we;
  assign bus.mem_addr_sel = asel;
  assign bus.ir_we        = irwe;
  assign bus.pc_we        = pcwe;
  assign bus.pc_src       = pcsrc;
  assign bus.alu_src_a    = sa;
  assign bus.alu_src_b    = sb;
  assign bus.alu_op       = op;
  assign bus.reg_we       = rwe;
  assign bus.mem_to_reg   = m2r;
  assign bus.retire       = ret;
  assign bus.halted       = (state_q == S_HALT);
  assign bus.instr_count  = cnt_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: instruction-level trace model pushes per-cycle
// expected control vectors; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam int CW = 4;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct packed {
    logic [2:0]    st;
    logic          req, we, asel;
    logic          irwe, pcwe, pcsrc;
    logic [1:0]    sa, sb, op;
    logic          rwe, m2r, ret, hlt;
    logic [CW-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   mcount = 0;
  obs_t m_e, m_a;

  function automatic obs_t sample();
    obs_t a;
    a.st    = bus.state_dbg;
    a.req   = bus.mem_req;
    a.we    = bus.mem_we;
    a.asel  = bus.mem_addr_sel;
    a.irwe  = bus.ir_we;
    a.pcwe  = bus.pc_we;
    a.pcsrc = bus.pc_src;
    a.sa    = bus.alu_src_a;
    a.sb    = bus.alu_src_b;
    a.op    = bus.alu_op;
    a.rwe   = bus.reg_we;
    a.m2r   = bus.mem_to_reg;
    a.ret   = bus.retire;
    a.hlt   = bus.halted;
    a.cnt   = bus.instr_count;
    return a;
  endfunction

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      m_e = expq.pop_front();
      m_a = sample();
      checks++;
      if (m_a !== m_e) begin
        errors++;
        $display("FAIL cycle_vec t=%0t st=%0d got %h want %h",
                 $time, m_e.st, m_a, m_e);
      end
    end
  end

  function automatic obs_t z(input logic [2:0] st);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.hlt = (st == 3'd6);
    return o;
  endfunction

  task automatic cyc(input logic [6:0] opc, input logic [2:0] f3,
                     input logic az, input logic rdy, input obs_t e);
    bus.opcode    = opc;
    bus.funct3    = f3;
    bus.alu_zero  = az;
    bus.mem_ready = rdy;
    e.cnt = CW'(mcount);
    expq.push_back(e);
    if (e.ret) mcount = (mcount + 1) % (1 << CW);
    @(posedge clk);
    #1;
  endtask

  task automatic rcyc(input obs_t e);
    cyc(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), e);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    mcount  = 0;
    for (int i = 0; i < n; i++) rcyc(z(3'd0));
    reset_n = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3,
                           input int wf, input int wm,
                           input bit abort);
    obs_t e;
    logic az;
    logic tk;
    bit   is_ld, is_st;
    is_ld = (opc == OP_LD);
    is_st = (opc == OP_ST);
    for (int i = 0; i <= wf; i++) begin
      e      = z(3'd0);
      e.req  = 1'b1;
      e.sb   = 2'b01;
      e.irwe = (i == wf);
      e.pcwe = (i == wf);
      cyc(7'($urandom), 3'($urandom), 1'($urandom), (i == wf), e);
    end
    e    = z(3'd1);
    e.sa = 2'b01;
    e.sb = 2'b10;
    cyc(opc, f3, 1'($urandom), 1'($urandom), e);
    if (opc == OP_BR) begin
      az = 1'($urandom);
      tk = (f3 == 3'b000 && az) || (f3 == 3'b001 && !az);
      e       = z(3'd5);
      e.sa    = 2'b10;
      e.op    = 2'b01;
      e.pcwe  = tk;
      e.pcsrc = tk;
      e.ret   = 1'b1;
      cyc(opc, f3, az, 1'($urandom), e);
      return;
    end
    if (!(opc == OP_R || opc == OP_I || is_ld || is_st)) begin
      for (int i = 0; i < 20; i++) rcyc(z(3'd6));
      return;
    end
    e    = z(3'd2);
    e.sa = 2'b10;
    e.sb = (opc == OP_R) ? 2'b00 : 2'b10;
    e.op = (opc == OP_R || opc == OP_I) ? 2'b10 : 2'b00;
    cyc(opc, f3, 1'($urandom), 1'($urandom), e);
    if (is_ld || is_st) begin
      for (int i = 0; i <= wm; i++) begin
        e      = z(3'd3);
        e.req  = 1'b1;
        e.asel = 1'b1;
        e.we   = is_st;
        if (abort) begin
          bus.mem_ready = 1'b0;
          expq.push_back(e);
          e.cnt = CW'(mcount);
          expq[$] = e;
          @(negedge clk);
          #1;
          reset_n = 1'b0;
          #1;
          checks++;
          if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL abort_mem req=%b we=%b want 0 0",
                     bus.mem_req, bus.mem_we);
          end
          @(posedge clk);
          #1;
          do_reset(1);
          return;
        end
        e.ret = is_st && (i == wm);
        cyc(opc, f3, 1'($urandom), (i == wm), e);
      end
    end
    if (!is_st) begin
      e     = z(3'd4);
      e.rwe = 1'b1;
      e.m2r = is_ld;
      e.ret = 1'b1;
      cyc(opc, f3, 1'($urandom), 1'($urandom), e);
    end
  endtask

  logic [6:0] ops [5];

  initial begin
    ops[0] = OP_R;
    ops[1] = OP_I;
    ops[2] = OP_LD;
    ops[3] = OP_ST;
    ops[4] = OP_BR;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    run_instr(OP_R, 3'b000, 0, 0, 0);
    run_instr(OP_LD, 3'b010, 2, 2, 0);
    run_instr(OP_ST, 3'b010, 0, 0, 0);
    for (int k = 0; k < 4; k++) run_instr(OP_BR, 3'b000, 0, 0, 0);
    for (int k = 0; k < 4; k++) run_instr(OP_BR, 3'b001, 0, 0, 0);
    for (int k = 0; k < 3; k++) run_instr(OP_BR, 3'b100, 0, 0, 0);
    do_reset(1);
    for (int k = 0; k < 17; k++) run_instr(OP_R, 3'b000, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      run_instr(ops[$urandom_range(0, 4)],
                3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    run_instr(OP_ST, 3'b010, 1, 3, 1);
    run_instr(OP_I, 3'b000, 0, 0, 0);
    run_instr(OP_BAD, 3'b000, 1, 0, 0);
    do_reset(2);
    run_instr(OP_R, 3'b000, 0, 0, 0);
    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain left=%0d want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
